regfile_dump_reader: RTL

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

---
 rtl/regfile_dump_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Streams the register file out one entry per cycle over a valid/ready port,
// reading through a single asynchronous read port of the register file.
`ifndef ADDR_LEN
`define ADDR_LEN 5
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module regfile_dump_reader #(
  parameter int BRAM_ADDR_WIDTH = `ADDR_LEN,
  parameter int BRAM_DATA_WIDTH = `DATA_LEN,
  parameter int DATA_DEPTH      = 32,
  parameter int FIRST_ADDR      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH-1:0] raddr,
  input  logic [BRAM_DATA_WIDTH-1:0] rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BRAM_ADDR_WIDTH-1:0] out_addr,
  output logic [BRAM_DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [BRAM_ADDR_WIDTH-1:0] FIRST_PTR = BRAM_ADDR_WIDTH'(FIRST_ADDR);
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_PTR  = BRAM_ADDR_WIDTH'(DATA_DEPTH - 1);

  state_t                     r_state;
  logic [BRAM_ADDR_WIDTH-1:0] r_ptr;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_valid;
  logic [BRAM_ADDR_WIDTH-1:0] r_out_addr;
  logic [BRAM_DATA_WIDTH-1:0] r_out_data;
  logic [BRAM_ADDR_WIDTH-1:0] w_ptr_inc;

  // While a word is held, the read port already looks one entry ahead so the
  // next word can be captured on the same edge that accepts the current one.
  assign w_ptr_inc = r_ptr + BRAM_ADDR_WIDTH'(1);
  assign raddr     = (r_state == S_HOLD) ? w_ptr_inc : r_ptr;

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;

  // Dump sequencer: pointer, output word register and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= FIRST_PTR;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ptr   <= FIRST_PTR;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          if (start && !abort) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_ptr   <= FIRST_PTR;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
          end else begin
            r_out_data <= rdata;
            r_out_addr <= r_ptr;
            r_valid    <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_ptr   <= FIRST_PTR;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
          end else if (out_ready) begin
            if (r_ptr == LAST_PTR) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ptr      <= w_ptr_inc;
              r_out_data <= rdata;
              r_out_addr <= w_ptr_inc;
            end
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ptr   <= FIRST_PTR;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ptr   <= FIRST_PTR;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
